// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - PS/2 line and Z180 register-read signals for ps2_rx_fifo
interface ps2_rx_fifo_if;
   logic       KB_CLK;
   logic       KB_DATA;
   logic       SEL;
   logic       A0;
   logic [7:0] DOUT;
   logic       INT;

   // Drives the keyboard lines and the read strobe; sees read data and interrupt
   modport master (
      output KB_CLK, KB_DATA, SEL, A0,
      input  DOUT, INT
   );

   // The receiver itself
   modport slave (
      input  KB_CLK, KB_DATA, SEL, A0,
      output DOUT, INT
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with scan-code FIFO, status flags and IRQ
module ps2_rx_fifo #(
   parameter int DEPTH        = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int FILTER       = 4,
   parameter int SAMPLE_DELAY = 8,
   parameter int TIMEOUT      = 4096
) (
   input  logic          CLK,
   input  logic          RST,
   ps2_rx_fifo_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = $clog2(FILTER + 1);
   localparam int DW = $clog2(SAMPLE_DELAY + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE} state_t;

   logic [SYNC_STAGES-1:0] kc_sync_q, kd_sync_q;
   logic                   kc_s, kd_s;
   logic [FW-1:0]          flt_cnt_q;
   logic                   kc_f_q, kc_f_prev_q;
   logic                   fall;

   state_t                 state_q, state_d;
   logic [DW-1:0]          dly_q, dly_d;
   logic [3:0]             bitcnt_q, bitcnt_d;
   logic [9:0]             frame_q, frame_d;
   logic [TW-1:0]          to_cnt_q, to_cnt_d;
   logic                   frame_done, to_abort;

   logic [10:0]            rx_frame;
   logic                   ferr_frame, perr_frame, good;

   logic [7:0]             mem_q [DEPTH];
   logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]          count_q;
   logic                   full, not_empty;
   logic                   sel_q, a0_q;
   logic                   pop_req, st_clr, do_pop, do_push;
   logic                   perr_q, ferr_q, ovr_q;
   logic                   perr_set, ferr_set, ovr_set;
   logic [7:0]             status;

   assign kc_s = kc_sync_q[SYNC_STAGES-1];
   assign kd_s = kd_sync_q[SYNC_STAGES-1];
   assign fall = kc_f_prev_q & ~kc_f_q;

   // Synchronise the PS/2 lines and debounce the clock; idle line is high
   always_ff @(posedge CLK) begin
      if (!RST) begin
         kc_sync_q   <= '1;
         kd_sync_q   <= '1;
         flt_cnt_q   <= '0;
         kc_f_q      <= 1'b1;
         kc_f_prev_q <= 1'b1;
      end else begin
         kc_sync_q   <= {kc_sync_q[SYNC_STAGES-2:0], bus.KB_CLK};
         kd_sync_q   <= {kd_sync_q[SYNC_STAGES-2:0], bus.KB_DATA};
         kc_f_prev_q <= kc_f_q;
         if (kc_s == kc_f_q) begin
            flt_cnt_q <= '0;
         end else if (flt_cnt_q == FW'(FILTER - 1)) begin
            kc_f_q    <= kc_s;
            flt_cnt_q <= '0;
         end else begin
            flt_cnt_q <= flt_cnt_q + FW'(1);
         end
      end
   end

   // Receive FSM state register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         dly_q    <= '0;
         bitcnt_q <= '0;
         frame_q  <= '0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         bitcnt_q <= bitcnt_d;
         frame_q  <= frame_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Receive FSM next state: wait out the sample delay, capture bits, abort stalled frames
   always_comb begin
      state_d    = state_q;
      dly_d      = dly_q;
      bitcnt_d   = bitcnt_q;
      frame_d    = frame_q;
      to_cnt_d   = to_cnt_q;
      frame_done = 1'b0;
      to_abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_WAIT;
               dly_d   = '0;
            end else if (bitcnt_q != 4'd0) begin
               if (to_cnt_q == TW'(TIMEOUT)) begin
                  to_abort = 1'b1;
                  bitcnt_d = '0;
                  to_cnt_d = '0;
               end else begin
                  to_cnt_d = to_cnt_q + TW'(1);
               end
            end else begin
               to_cnt_d = '0;
            end
         end
         S_WAIT: begin
            if (dly_q == DW'(SAMPLE_DELAY - 1)) state_d = S_SAMPLE;
            else                                dly_d   = dly_q + DW'(1);
         end
         S_SAMPLE: begin
            state_d = S_IDLE;
            if (bitcnt_q == 4'd10) begin
               frame_done = 1'b1;
               bitcnt_d   = '0;
            end else begin
               frame_d[bitcnt_q] = kd_s;
               bitcnt_d          = bitcnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (fall) to_cnt_d = '0;
   end

   // The stop bit is taken live in the final SAMPLE cycle
   assign rx_frame   = {kd_s, frame_q};
   assign ferr_frame = rx_frame[0] | ~rx_frame[10];
   assign perr_frame = ~(^rx_frame[9:1]);
   assign good       = frame_done & ~ferr_frame & ~perr_frame;

   assign full      = (count_q == CW'(DEPTH));
   assign not_empty = (count_q != '0);
   assign pop_req   = sel_q & ~bus.SEL & ~a0_q;
   assign st_clr    = sel_q & ~bus.SEL & a0_q;
   assign do_pop    = pop_req & not_empty;
   assign do_push   = good & (~full | do_pop);
   assign ovr_set   = good & full & ~do_pop;
   assign perr_set  = frame_done & perr_frame;
   assign ferr_set  = (frame_done & ferr_frame) | to_abort;

   // FIFO pointers, count, read-strobe edge detect and sticky error flags
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         sel_q    <= 1'b0;
         a0_q     <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sel_q <= bus.SEL;
         if (bus.SEL) a0_q <= bus.A0;
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         perr_q <= (perr_q & ~st_clr) | perr_set;
         ferr_q <= (ferr_q & ~st_clr) | ferr_set;
         ovr_q  <= (ovr_q  & ~st_clr) | ovr_set;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= rx_frame[8:1];
   end

   assign status   = {3'b000, ovr_q, ferr_q, perr_q, full, not_empty};
   assign bus.DOUT = !bus.SEL  ? 8'h00 :
                     bus.A0    ? status :
                     not_empty ? mem_q[rd_ptr_q] : 8'h00;
   assign bus.INT  = not_empty;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
   localparam int DEPTH        = 4;
   localparam int SYNC_STAGES  = 2;
   localparam int FILTER       = 4;
   localparam int SAMPLE_DELAY = 8;
   localparam int TIMEOUT      = 4096;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] exp_q [$];
   logic       m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

   ps2_rx_fifo_if bus();

   ps2_rx_fifo #(
      .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER),
      .SAMPLE_DELAY(SAMPLE_DELAY), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it differs
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      bus.KB_DATA = b;
      repeat (20) @(negedge clk);
      bus.KB_CLK = 1'b0;
      repeat (40) @(negedge clk);
      bus.KB_CLK = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   // Start bit plus the first n data bits of d, then leave the line idle
   task automatic send_partial(input logic [7:0] d, input int n);
      ps2_bit(1'b0);
      for (int i = 0; i < n; i++) ps2_bit(d[i]);
   endtask

   // Full frame; the expected outcome goes to the scoreboard
   task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic bad_stop);
      logic par;
      par = ~(^d) ^ flip_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(par);
      ps2_bit(~bad_stop);
      repeat (30) @(negedge clk);
      if (flip_par) m_perr = 1'b1;
      if (bad_stop) m_ferr = 1'b1;
      if (!flip_par && !bad_stop) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else                      m_ovr = 1'b1;
      end
   endtask

   task automatic read_reg(input logic a0, output logic [7:0] v);
      @(negedge clk);
      bus.A0  = a0;
      bus.SEL = 1'b1;
      repeat (3) @(negedge clk);
      v = bus.DOUT;
      bus.SEL = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic read_data(input string tag);
      logic [7:0] v, e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      read_reg(1'b0, v);
      check(tag, {8'h00, v}, {8'h00, e});
   endtask

   task automatic read_status(input string tag);
      logic [7:0] v, e;
      e = {3'b000, m_ovr, m_ferr, m_perr, exp_q.size() == DEPTH, exp_q.size() != 0};
      read_reg(1'b1, v);
      check(tag, {8'h00, v}, {8'h00, e});
      m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
   endtask

   task automatic wait_int(input string tag, input logic want, input int budget);
      int n;
      n = 0;
      while (bus.INT !== want && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {15'd0, bus.INT}, {15'd0, want});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] st;
      bus.KB_CLK = 1'b1; bus.KB_DATA = 1'b1; bus.SEL = 1'b0; bus.A0 = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_int", {15'd0, bus.INT}, 16'h0);
      check("reset_dout_nosel", {8'h00, bus.DOUT}, 16'h0);
      check("reset_bitcnt", {12'h0, dut.bitcnt_q}, 16'h0);
      read_status("reset_status");

      // single good frame
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_int("int_after_1c", 1'b1, 200);
      read_status("status_one");
      read_data("data_1c");
      check("int_after_pop", {15'd0, bus.INT}, 16'h0);
      read_status("status_empty");

      // two frames back to back, then a read of the empty FIFO
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      read_status("status_two");
      read_data("data_f0");
      read_data("data_1c_2");
      read_data("data_empty");

      // parity error, then bad stop bit
      send_frame(8'h1C, 1'b1, 1'b0);
      check("int_par_err", {15'd0, bus.INT}, 16'h0);
      read_status("status_perr");
      read_status("status_perr_cleared");
      send_frame(8'h55, 1'b0, 1'b1);
      read_status("status_ferr_stop");

      // overflow
      for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0);
      read_status("status_full_ovr");
      for (int i = 0; i < DEPTH; i++) read_data($sformatf("data_fill_%0d", i));
      read_data("data_after_drain");
      read_status("status_after_drain");

      // timeout of a truncated frame
      send_partial(8'hA5, 4);
      check("bitcnt_partial", {12'h0, dut.bitcnt_q}, 16'd5);
      repeat (TIMEOUT + SAMPLE_DELAY + 50) @(negedge clk);
      m_ferr = 1'b1;
      check("bitcnt_timeout", {12'h0, dut.bitcnt_q}, 16'h0);
      send_frame(8'h1C, 1'b0, 1'b0);
      read_status("status_timeout");
      read_data("data_after_timeout");

      // glitch shorter than the filter
      @(negedge clk);
      bus.KB_CLK = 1'b0;
      repeat (FILTER - 1) @(negedge clk);
      bus.KB_CLK = 1'b1;
      repeat (50) @(negedge clk);
      check("bitcnt_glitch", {12'h0, dut.bitcnt_q}, 16'h0);
      check("state_glitch", {14'h0, dut.state_q}, 16'h0);
      send_frame(8'h5A, 1'b0, 1'b0);
      read_data("data_after_glitch");

      // reset in the middle of a frame with data queued
      send_frame(8'h33, 1'b0, 1'b0);
      send_partial(8'hFF, 5);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      @(negedge clk);
      check("int_after_rst", {15'd0, bus.INT}, 16'h0);
      check("bitcnt_after_rst", {12'h0, dut.bitcnt_q}, 16'h0);
      read_status("status_after_rst");
      send_frame(8'h1C, 1'b0, 1'b0);
      read_data("data_after_rst");

      read_reg(1'b1, st);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
